// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of datamemory.
// Serialises one access at a time, rejects illegal/misaligned accesses, registers load data.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [DM_ADDRESS-1:0] addr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [2:0]            funct3_0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [DM_ADDRESS-1:0] addr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [2:0]            funct3_1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_W-1:0]     rdata0,
    output logic [DATA_W-1:0]     rdata1,
    output logic                  err0,
    output logic                  err1,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
);

    // state | meaning
    // IDLE  | no access in flight, arbitrating
    // ISSUE | command register drives memory, gnt/err pulse
    // RESP  | rvalid for the previous load, arbitrating
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state_q, state_d;
    logic                  last_q;
    logic                  sel_q;
    logic                  cmd_we_q;
    logic [DM_ADDRESS-1:0] cmd_addr_q;
    logic [DATA_W-1:0]     cmd_wdata_q;
    logic [2:0]            cmd_f3_q;
    logic [DATA_W-1:0]     rdata0_q, rdata1_q;

    logic bad;
    logic any_req;
    logic pick;
    logic last_eff;
    logic ld_cmd;
    logic issue;
    logic good_load;

    always_comb begin
        bad = 1'b0;
        if (cmd_we_q) begin
            bad = cmd_f3_q[2] | (cmd_f3_q[1:0] == 2'b11);
        end else begin
            bad = (cmd_f3_q[1:0] == 2'b11) | (cmd_f3_q[2] & cmd_f3_q[1]);
        end
        if (cmd_f3_q[1:0] == 2'b01 && cmd_addr_q[0]) begin
            bad = 1'b1;
        end
        if (cmd_f3_q[1:0] == 2'b10 && cmd_addr_q[1:0] != 2'b00) begin
            bad = 1'b1;
        end
    end

    assign issue     = (state_q == ISSUE);
    assign good_load = issue & ~cmd_we_q & ~bad;
    assign any_req   = req0 | req1;
    // Arbitration inside ISSUE must already see the port being granted as "last".
    assign last_eff  = issue ? sel_q : last_q;
    assign pick      = (req0 & req1) ? ~last_eff : req1;

    always_comb begin
        state_d = state_q;
        ld_cmd  = 1'b0;
        unique case (state_q)
            IDLE, RESP: begin
                if (any_req) begin
                    ld_cmd  = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (good_load) begin
                    state_d = RESP;
                end else if (any_req) begin
                    ld_cmd  = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_f3_q    <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                last_q <= sel_q;
            end
            if (good_load) begin
                if (sel_q) begin
                    rdata1_q <= rd;
                end else begin
                    rdata0_q <= rd;
                end
            end
            if (ld_cmd) begin
                sel_q       <= pick;
                cmd_we_q    <= pick ? we1 : we0;
                cmd_addr_q  <= pick ? addr1 : addr0;
                cmd_wdata_q <= pick ? wdata1 : wdata0;
                cmd_f3_q    <= pick ? funct3_1 : funct3_0;
            end
        end
    end

    // Reset gating keeps an aborted ISSUE from writing memory or signalling a grant.
    assign gnt0     = rst_n & issue & ~sel_q;
    assign gnt1     = rst_n & issue & sel_q;
    assign err0     = gnt0 & bad;
    assign err1     = gnt1 & bad;
    assign rvalid0  = rst_n & (state_q == RESP) & ~sel_q;
    assign rvalid1  = rst_n & (state_q == RESP) & sel_q;
    assign MemRead  = rst_n & issue & ~cmd_we_q & ~bad;
    assign MemWrite = rst_n & issue & cmd_we_q & ~bad;
    assign a        = cmd_addr_q;
    assign wd       = cmd_wdata_q;
    assign Funct3   = cmd_f3_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the `datamemory` block. It shares the single data memory between the pipeline MEM stage (port 0) and a secondary master such as a DMA or debug loader (port 1). It serialises their accesses, performs round-robin arbitration, rejects misaligned or unsupported accesses without touching memory, and returns registered read data with a valid pulse.

## Interface
- `DM_ADDRESS`, 9: byte-address width presented to memory.
- `DATA_W`, 32: data width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req0`/`req1` in 1: access request; held high with fields stable until `gnt` is seen.
- `we0`/`we1` in 1: 1 = store, 0 = load.
- `addr0`/`addr1` in DM_ADDRESS: byte address.
- `wdata0`/`wdata1` in DATA_W: store data, unshifted, in LSBs.
- `funct3_0`/`funct3_1` in 3: RISC-V load/store funct3.
- `gnt0`/`gnt1` out 1: one-cycle pulse; the request was accepted this cycle.
- `rvalid0`/`rvalid1` out 1: one-cycle pulse; `rdata` is valid.
- `rdata0`/`rdata1` out DATA_W: registered load result; holds its value until the next load on that port.
- `err0`/`err1` out 1: one-cycle pulse, concurrent with `gnt`; access rejected.
- `MemRead`, `MemWrite` out 1: to `datamemory`.
- `a` out DM_ADDRESS: to `datamemory`.
- `wd` out DATA_W: to `datamemory`.
- `Funct3` out 3: to `datamemory`.
- `rd` in DATA_W: from `datamemory`.

## Operation
- States are IDLE, ISSUE and RESP. One access is outstanding at a time.
- **Arbitration.** Evaluated in IDLE and RESP.
  - Single request: that port wins.
  - Both requesting: the port not granted last wins.
  - `last` pointer resets to 1, so port 0 wins the first tie.
  - The winner's we, addr, wdata and funct3 are latched into the command register, `sel` is latched, and the state moves to ISSUE.
  - If neither port requests, the state moves to IDLE.
- **ISSUE (one cycle).**
  - `gnt[sel]`=1.
  - `a`, `wd` and `Funct3` are driven from the command register.
  - `MemRead`=~we & ~bad. `MemWrite`=we & ~bad.
  - On a good load, `rd` is captured into `rdata[sel]` at the cycle end; next state is RESP.
  - On a store or a bad access, next state is arbitration as in IDLE: direct to ISSUE if a request is pending, else IDLE.
  - `last` is updated to `sel`.
- **RESP (one cycle).** `rvalid[sel]`=1, and arbitration runs concurrently.
- **Bad access.** `bad` is set, and `err[sel]` pulses with `gnt`, for any of:
  - Load funct3 not in {000, 001, 010, 100, 101}.
  - Store funct3 not in {000, 001, 010}.
  - Halfword (funct3[1:0]=01) with addr[0]=1.
  - Word (funct3[1:0]=10) with addr[1:0]≠00.
  - On a bad access, memory strobes stay 0 and no `rvalid` is issued.
- **Idle memory outputs.** When not in ISSUE, `MemRead`=`MemWrite`=0. `a`, `wd` and `Funct3` hold the command register.
- `gnt0` and `gnt1` are never high in the same cycle. The same holds for `rvalid0`/`rvalid1`.
- A request dropped before grant is simply not serviced; this is not an error.

## Timing
- **Reset values** (while `rst_n`=0 at a rising edge):
  - state=IDLE, `last`=1, command register=0.
  - `gnt*`, `rvalid*`, `err*`, `MemRead`, `MemWrite` = 0.
  - `rdata*`=0, `a`=0, `wd`=0, `Funct3`=0.
- `MemRead` and `MemWrite` are additionally gated by `rst_n`. A reset asserted during ISSUE must not produce a write, and the aborted access is discarded with no `gnt` and no `rvalid` afterwards.
- **Load latency:** `req` sampled high at edge E0; `gnt` high during cycle E0–E1; `rvalid` plus `rdata` high during E1–E2.
- **Throughput with continuous requests:**
  - Loads: one every 2 cycles (ISSUE, RESP, ISSUE, ...).
  - Stores and bad accesses: one per cycle.
- Memory is sampled during ISSUE only; `rd` must be settled before the ISSUE-ending edge. `datamemory` reads combinationally and writes on the falling edge.
- **Starvation bound:** with both ports requesting continuously, each port is granted at least every second grant.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `req0`=`req1`=1 → all outputs 0, no memory strobe. Release → `gnt0` is the first grant (`last`=1).
- **Single store/load:**
  - Port 0 SW addr 0x010, wdata 0xDEADBEEF → `gnt0` plus `MemWrite` for exactly 1 cycle.
  - Then port 1 LW 0x010 → `gnt1` 1 cycle later, `rvalid1` the following cycle with `rdata1`=0xDEADBEEF.
- **Contention:** both ports issue LW continuously for 8 grants → grants alternate 0,1,0,1…, and each `rvalid` follows its `gnt` by exactly 1 cycle on the same port.
- **Misaligned:**
  - Port 0 LW addr 0x012 → `gnt0`=`err0`=1, `MemRead`=0, no `rvalid0`.
  - Port 1 SH addr 0x005 → `err1`, `MemWrite`=0.
  - Port 0 LH 0x012 → accepted.
- **Byte ops:**
  - SB 0xA5 to 0x023, then LB 0x023 → `rdata`=0xFFFFFFA5.
  - LBU 0x023 → `rdata`=0x000000A5.
- **Reset mid-operation:** assert `rst_n`=0 during ISSUE of SW 0x030 (data 0x11111111), previously holding 0 → no `MemWrite` pulse; a later LW 0x030 returns 0.
